// File: rtl/supersonic_trigger_if.sv
// Handshake and sensor signals between the ranging initiator and its controller.
// The controller drives start/auto_en/echo and observes the trigger and status pulses.
interface supersonic_trigger_if;
    logic start;
    logic auto_en;
    logic echo;
    logic trigger;
    logic busy;
    logic done;
    logic no_echo;
    logic echo_stuck;

    modport master (
        output start, auto_en, echo,
        input  trigger, busy, done, no_echo, echo_stuck
    );

    modport slave (
        input  start, auto_en, echo,
        output trigger, busy, done, no_echo, echo_stuck
    );
endinterface

// File: rtl/supersonic_trigger.sv
// Ultrasonic ranging initiator: trigger pulse, echo rise/fall supervision with
// timeouts, and a fixed holdoff after every attempt. One shared cycle counter.
module supersonic_trigger #(
    parameter int TRIG_CYCLES      = 500,
    parameter int ECHO_WAIT_CYCLES = 50000,
    parameter int ECHO_MAX_CYCLES  = 1900000,
    parameter int HOLDOFF_CYCLES   = 2500000,
    parameter int CNT_W            = 22
) (
    input logic                clk,
    input logic                rst_n,
    supersonic_trigger_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        WAIT_FALL,
        HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(ECHO_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST     = CNT_W'(ECHO_MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic               s1, s2, s3;
    logic               rise, fall;
    logic               start_pend;
    logic               clr_pend;
    logic               done_next, no_echo_next, stuck_next;

    // s1/s2 resolve metastability on the asynchronous pad; s3 is edge history.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values and the synchronizer chain shifts by exactly one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.echo;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state   = state;
        clr_pend     = 1'b0;
        done_next    = 1'b0;
        no_echo_next = 1'b0;
        stuck_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start || start_pend || bus.auto_en) begin
                    next_state = TRIG;
                    clr_pend   = 1'b1;
                end
            end
            TRIG: begin
                if (cnt == TRIG_LAST) next_state = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    next_state = WAIT_FALL;
                end else if (cnt == WAIT_LAST) begin
                    no_echo_next = 1'b1;
                    next_state   = HOLDOFF;
                end
            end
            WAIT_FALL: begin
                // A fall coinciding with the timeout is still a valid echo.
                if (fall) begin
                    done_next  = 1'b1;
                    next_state = HOLDOFF;
                end else if (cnt == MAX_LAST) begin
                    stuck_next = 1'b1;
                    next_state = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt == HOLDOFF_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            start_pend <= 1'b0;
            bus.trigger    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.no_echo    <= 1'b0;
            bus.echo_stuck <= 1'b0;
        end else begin
            state <= next_state;
            // Counter restarts on every state change and idles at zero.
            if (next_state != state || state == IDLE) cnt <= '0;
            else                                      cnt <= cnt + 1'b1;
            if (clr_pend)                          start_pend <= 1'b0;
            else if (bus.start && state != IDLE)   start_pend <= 1'b1;
            bus.trigger    <= (next_state == TRIG);
            bus.busy       <= (next_state != IDLE);
            bus.done       <= done_next;
            bus.no_echo    <= no_echo_next;
            bus.echo_stuck <= stuck_next;
        end
    end

endmodule
